// File: rtl/wb_select_pipe_if.sv
// Writeback select pipe bus: retiring-instruction request, load-data
// return path, register-file write port and status outputs.
//
// Handshake: a request transfers on a rising clk edge where
// in_valid && in_ready; mem_rvalid is a single-cycle qualifier for
// mem_rdata and is only consumed while a load is pending.
interface wb_select_pipe_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  // request side
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [RA_W-1:0] rd;
  logic            mem_to_reg;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc_plus_four;
  logic [XLEN-1:0] alu_data;
  logic [1:0]      addr_lo;
  // load data return
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  // register-file write port and status
  logic            rf_we;
  logic [RA_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic [31:0]     retire_cnt;
  logic [1:0]      state_dbg;

  modport slave (
    input  in_valid, opcode, funct3, rd, mem_to_reg,
    input  pc_plus_imm, imm, pc_plus_four, alu_data, addr_lo,
    input  mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_waddr, rf_wdata, busy, retire_cnt, state_dbg
  );

  modport master (
    output in_valid, opcode, funct3, rd, mem_to_reg,
    output pc_plus_imm, imm, pc_plus_four, alu_data, addr_lo,
    output mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_waddr, rf_wdata, busy, retire_cnt, state_dbg
  );
endinterface

// File: rtl/wb_select_pipe.sv
// Writeback result selection stage. Picks the register-file write value for
// a retiring instruction (immediate, pc-relative, ALU or link address), or
// parks a load until its data returns and then aligns/extends it. Writes are
// registered and appear one cycle after the deciding edge.
module wb_select_pipe #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input logic              clk,
  input logic              rst_n,
  wb_select_pipe_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_MEM = 2'd1;
  localparam logic [1:0] S_WRITE    = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]      state_q, state_d;
  logic            rf_we_q;
  logic [RA_W-1:0] rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [31:0]     retire_cnt_q;

  // load request fields held while waiting for data
  logic [2:0]      ld_funct3_q;
  logic [RA_W-1:0] ld_rd_q;
  logic [1:0]      ld_addr_q;

  logic            accept;
  logic            capture;
  logic            wr_fire;
  logic [RA_W-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            nl_hit;
  logic [XLEN-1:0] nl_res;
  logic [31:0]     word32;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_res;

  // A new request can only be taken when no load is outstanding.
  assign bus.in_ready   = (state_q != S_WAIT_MEM);
  assign bus.busy       = (state_q == S_WAIT_MEM);
  assign bus.state_dbg  = state_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.retire_cnt = retire_cnt_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Non-load result mux; opcodes outside the table produce no write.
  always_comb begin
    nl_hit = 1'b1;
    nl_res = '0;
    case (bus.opcode)
      OP_LUI:           nl_res = bus.imm;
      OP_AUIPC:         nl_res = bus.pc_plus_imm;
      OP_REG, OP_IMM:   nl_res = bus.alu_data;
      OP_JAL, OP_JALR:  nl_res = bus.pc_plus_four;
      default:          nl_hit = 1'b0;
    endcase
  end

  // Load data alignment: pick byte/half by the captured address bits and
  // extend to XLEN; word and unknown sizes pass the low 32 bits signed.
  always_comb begin
    word32   = bus.mem_rdata[31:0];
    half_sel = ld_addr_q[1] ? word32[31:16] : word32[15:0];
    case (ld_addr_q)
      2'd0:    byte_sel = word32[7:0];
      2'd1:    byte_sel = word32[15:8];
      2'd2:    byte_sel = word32[23:16];
      default: byte_sel = word32[31:24];
    endcase
    case (ld_funct3_q)
      3'b000:  load_res = XLEN'(signed'(byte_sel));
      3'b100:  load_res = XLEN'(byte_sel);
      3'b001:  load_res = XLEN'(signed'(half_sel));
      3'b101:  load_res = XLEN'(half_sel);
      default: load_res = XLEN'(signed'(word32));
    endcase
  end

  // Next-state and write decision. rd=0 never writes, whatever the source.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    wr_fire = 1'b0;
    wr_addr = rf_waddr_q;
    wr_data = rf_wdata_q;
    case (state_q)
      S_WAIT_MEM: begin
        if (bus.mem_rvalid) begin
          state_d = S_WRITE;
          wr_fire = (ld_rd_q != '0);
          wr_addr = ld_rd_q;
          wr_data = load_res;
        end
      end
      S_IDLE, S_WRITE: begin
        if (accept) begin
          if (bus.mem_to_reg) begin
            state_d = S_WAIT_MEM;
            capture = 1'b1;
          end else begin
            state_d = S_WRITE;
            wr_fire = nl_hit && (bus.rd != '0);
            wr_addr = bus.rd;
            wr_data = nl_res;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered write port and retire counter. The counter steps on
  // the same edge that raises rf_we, so it already includes the write that
  // is visible on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rf_we_q <= wr_fire;
      if (wr_fire) begin
        rf_waddr_q   <= wr_addr;
        rf_wdata_q   <= wr_data;
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  // Capture load request fields at accept; a reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_funct3_q <= '0;
      ld_rd_q     <= '0;
      ld_addr_q   <= '0;
    end else if (capture) begin
      ld_funct3_q <= bus.funct3;
      ld_rd_q     <= bus.rd;
      ld_addr_q   <= bus.addr_lo;
    end
  end

endmodule

// File: doc/wb_select_pipe.md
WB_SELECT_PIPE -- requirements
Module: wb_select_pipe

Interface
REQ-001 Parameter: XLEN, default 32, width of all data/address-value buses (32 or 64 only).
REQ-002 Parameter: RA_W, default 5, register-file address width.
REQ-003 Port: clk  input  1  sole clock, rising-edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  writeback request offered this cycle.
REQ-006 Port: in_ready  output  1  request accepted when in_valid && in_ready at clock edge.
REQ-007 Port: opcode  input  7  RV opcode of the retiring instruction.
REQ-008 Port: funct3  input  3  load size/sign selector.
REQ-009 Port: rd  input  RA_W  destination register.
REQ-010 Port: mem_to_reg  input  1  instruction is a load.
REQ-011 Port: pc_plus_imm, imm, pc_plus_four, alu_data  input  XLEN each  candidate result sources.
REQ-012 Port: addr_lo  input  2  low bits of the load byte address.
REQ-013 Port: mem_rvalid  input  1  load data valid; mem_rdata  input  XLEN  load word.
REQ-014 Port: rf_we  output  1  register-file write strobe, one cycle per retired write.
REQ-015 Port: rf_waddr  output  RA_W; rf_wdata  output  XLEN  write address/data, meaningful only while rf_we=1.
REQ-016 Port: busy  output  1  high while a load is waiting for mem_rvalid.
REQ-017 Port: retire_cnt  output  32  count of rf_we pulses, wraps 0xFFFFFFFF->0.

Function
REQ-018 States: IDLE, WAIT_MEM, WRITE; one-hot or binary encoding, implementer's choice.
REQ-019 in_ready SHALL be 1 in IDLE and WRITE, 0 in WAIT_MEM.
REQ-020 Non-load accept (mem_to_reg=0) -> WRITE next cycle; rf_we=1 that cycle (latency 1).
REQ-021 Non-load result: lui 0110111->imm; auipc 0010111->pc_plus_imm; 0110011/0010011->alu_data; jal 1101111/jalr 1100111->pc_plus_four.
REQ-022 Any other opcode with mem_to_reg=0 SHALL retire with rf_we=0 (no write, no latch, no count).
REQ-023 Load accept -> WAIT_MEM; request fields (funct3, rd, addr_lo) captured at accept; mem_rvalid ignored outside WAIT_MEM.
REQ-024 In WAIT_MEM, mem_rvalid=1 -> WRITE next cycle with aligned load data; otherwise remain, no timeout.
REQ-025 Load alignment: LB 000 sign-extends byte addr_lo; LBU 100 zero-extends it; LH 001 sign-extends half selected by addr_lo[1]; LHU 101 zero-extends it; LW 010 and all other funct3 pass bits [31:0], sign-extended when XLEN=64.
REQ-026 rd=0 SHALL force rf_we=0 in WRITE for any source; no retire_cnt increment.
REQ-027 In WRITE, new accept -> WRITE again (back-to-back non-loads) or WAIT_MEM (load); no accept -> IDLE.
REQ-028 rf_waddr/rf_wdata SHALL be registered and hold last value when rf_we=0.
REQ-029 retire_cnt SHALL increment exactly on cycles where rf_we=1.
REQ-030 busy SHALL equal (state==WAIT_MEM).

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, rf_we=0, busy=0, rf_waddr=0, rf_wdata=0, retire_cnt=0.
REQ-032 Reset during WAIT_MEM SHALL discard the pending load; a mem_rvalid arriving after release in IDLE SHALL be ignored.
REQ-033 in_ready SHALL be 1 during and after reset (state IDLE).

Verification
REQ-034 lui, imm=0x12345000, rd=5 accepted cycle N -> cycle N+1 rf_we=1, rf_waddr=5, rf_wdata=0x12345000, retire_cnt=1.
REQ-035 LB funct3=000, addr_lo=2, rd=7; mem_rvalid after 3 wait cycles with mem_rdata=0x00800000 -> busy=1 for 3+ cycles, in_ready=0, then rf_wdata=0xFFFFFF80; LBU same data -> 0x00000080.
REQ-036 Three back-to-back addi (opcode 0010011) rd=1,2,3 on consecutive cycles -> three consecutive rf_we pulses, in_ready never drops, retire_cnt=3.
REQ-037 opcode 1100011 (branch) rd=4, and addi with rd=0 -> rf_we stays 0, retire_cnt unchanged.
REQ-038 Load accepted, rst_n pulsed low mid-WAIT_MEM, mem_rvalid=1 after release -> no rf_we, busy=0, retire_cnt=0.
REQ-039 Preload retire_cnt to 0xFFFFFFFF via forced counts, one more write -> retire_cnt=0.
